xpu_ack_ctrl: RTL and testbench
===============================

Name: xpu_ack_ctrl

Overview:
- Reduced lower-MAC controller with an AXI4-Lite register slave.
- Parses received 802.11 MAC headers from the PHY byte stream and matches Addr1 against the programmed MAC address.
- After a frame with good FCS that is addressed to this station, waits the configured turnaround and commands ACK transmission.
- Tracks the PHY TX handshake until the ACK is done.

Parameters:
- C_S00_AXI_DATA_WIDTH, 32, AXI data width (fixed 32).
- C_S00_AXI_ADDR_WIDTH, 8, AXI byte-address width.

Ports:
- s00_axi_aclk  in  1  sole clock.
- s00_axi_aresetn  in  1  asynchronous active-low reset.
- s00_axi_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready  AXI4-Lite write channels; standard widths (addr 8, data 32, strb 4, bresp 2).
- s00_axi_araddr/arvalid/arready, rdata/rresp/rvalid/rready  AXI4-Lite read channels; standard widths.
- pkt_header_valid_strobe  in  1  PHY SIGNAL-field decoded; marks start of frame.
- byte_in_strobe  in  1  qualifies byte_in.
- byte_in  in  8  MPDU byte.
- byte_count  in  16  index of byte_in within the MPDU.
- fcs_in_strobe  in  1  end of frame.
- fcs_ok  in  1  CRC result, valid with fcs_in_strobe.
- phy_tx_done  in  1  PHY finished transmission.
- mac_addr  out  48  {reg31[15:0], reg30}.
- addr1  out  48  received Addr1.
- addr1_valid  out  1  one-cycle pulse when Addr1 is complete.
- pkt_for_me  out  1  Addr1 == mac_addr; updated at addr1_valid, cleared at header strobe.
- start_tx_ack  out  1  one-cycle ACK transmit command.
- ack_tx_flag  out  1  high while an ACK transmission is in progress.

Behaviour:
- Reset: all registers 0, all outputs 0, FSM in IDLE, AXI ready/valid signals low.
- AXI write:
  - awready and wready pulse together for one cycle when awvalid and wvalid are both high and bvalid is low.
  - The register is written on that cycle, honouring wstrb.
  - bvalid rises the next cycle and holds until bready; bresp is always 0.
- AXI read:
  - arready pulses one cycle when arvalid is high and rvalid is low.
  - rvalid rises the next cycle with data and holds until rready; rresp is 0.
  - Unmapped addresses read 0; writes to them are ignored.
- Register map (word index = addr[7:2]):
  - 0x40 reg16: [15:0] SIFS cycles, [31:16] ACK timeout cycles (0 = none).
  - 0x48 reg18: [15:0] extra turnaround cycles.
  - 0x50 reg20: read-only count of ACKs started (32-bit, wraps).
  - 0x6C reg27: frame filter; bit0 mgmt, bit1 ctrl, bit2 data enables.
  - 0x78 reg30: MAC address [31:0].
  - 0x7C reg31: MAC address [47:32] in bits [15:0].
- Header parse:
  - On byte_in_strobe, the byte at byte_count 0 is latched as FC0: type = FC0[3:2].
  - Bytes at byte_count 4..9 go to addr1[8k+7:8k], k = byte_count-4 (little-endian).
  - addr1_valid pulses the cycle after byte 9 is captured.
  - pkt_header_valid_strobe clears the parse state and pkt_for_me.
- ACK qualification, evaluated at fcs_in_strobe. All of the following must hold:
  - fcs_ok = 1;
  - Addr1 complete and equal to mac_addr;
  - addr1[0] = 0 (unicast);
  - type is 0 or 2, and reg27 enable bit for that type is 1;
  - FSM is IDLE.
  - Control frames (type 1) never trigger an ACK.
- FSM:
  - IDLE → WAIT on a qualified fcs_in_strobe at cycle T; counter loads D = reg16[15:0] + reg18[15:0] (17-bit).
  - WAIT counts down; at T+1+D (T+1 if D = 0), start_tx_ack pulses for one cycle and ack_tx_flag rises. Go to ACK_TX; reg20 increments.
  - WAIT + pkt_header_valid_strobe → IDLE with no ACK (medium busy).
  - ACK_TX: ack_tx_flag stays high.
    - phy_tx_done → ack_tx_flag falls next cycle; go to IDLE.
    - If reg16[31:16] ≠ 0 and that many cycles elapse without phy_tx_done → IDLE, flag cleared.
  - Header strobes and qualified FCS events during ACK_TX are ignored.
- Asynchronous reset at any time returns the FSM to IDLE immediately and clears all outputs and registers.

Test Plan:
- Reset, write reg30 = 0xDDCCBBAA and reg31 = 0x0000FFEE → mac_addr = 48'hFFEEDDCCBBAA; read back both registers; bresp = 0.
- reg16 = 0x00140014, reg18 = 0x0A, reg27 = 0x3FFF; send a 128-byte data frame (FC 08 02, Addr1 AA BB CC DD EE FF), fcs_ok = 1 → pkt_for_me = 1; start_tx_ack single pulse exactly 31 cycles after fcs_in_strobe; ack_tx_flag high; reg20 = 1.
- Assert phy_tx_done 50 cycles after start_tx_ack → ack_tx_flag low the next cycle; FSM idle; a second identical frame produces a second ACK.
- Same frame with fcs_ok = 0, Addr1 ending 0x00, or reg27 bit2 = 0 → no start_tx_ack within 1000 cycles; reg20 unchanged.
- Qualified frame, then pkt_header_valid_strobe 5 cycles later → no ACK. Separately: ACK started and no phy_tx_done → ack_tx_flag drops after 20 cycles.
- Assert reset during WAIT → start_tx_ack never asserts; all registers read 0.

Source files
------------

// File: rtl/xpu_ack_ctrl_if.sv
// AXI4-Lite register bus between a host master and the xpu_ack_ctrl register slave.
interface xpu_ack_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   s00_axi_awaddr;
    logic                s00_axi_awvalid;
    logic                s00_axi_awready;
    logic [DATA_W-1:0]   s00_axi_wdata;
    logic [DATA_W/8-1:0] s00_axi_wstrb;
    logic                s00_axi_wvalid;
    logic                s00_axi_wready;
    logic [1:0]          s00_axi_bresp;
    logic                s00_axi_bvalid;
    logic                s00_axi_bready;
    logic [ADDR_W-1:0]   s00_axi_araddr;
    logic                s00_axi_arvalid;
    logic                s00_axi_arready;
    logic [DATA_W-1:0]   s00_axi_rdata;
    logic [1:0]          s00_axi_rresp;
    logic                s00_axi_rvalid;
    logic                s00_axi_rready;

    modport slave (
        input  s00_axi_awaddr, s00_axi_awvalid, s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
               s00_axi_bready, s00_axi_araddr, s00_axi_arvalid, s00_axi_rready,
        output s00_axi_awready, s00_axi_wready, s00_axi_bresp, s00_axi_bvalid,
               s00_axi_arready, s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid
    );

    modport master (
        output s00_axi_awaddr, s00_axi_awvalid, s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
               s00_axi_bready, s00_axi_araddr, s00_axi_arvalid, s00_axi_rready,
        input  s00_axi_awready, s00_axi_wready, s00_axi_bresp, s00_axi_bvalid,
               s00_axi_arready, s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid
    );
endinterface

// File: rtl/xpu_ack_ctrl.sv
// Reduced lower-MAC: parses Addr1 from the PHY byte stream, matches it to our MAC
// address and, after a good-FCS unicast frame, commands an ACK after the turnaround.
module xpu_ack_ctrl #(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 8
) (
    input  logic        s00_axi_aclk,
    input  logic        s00_axi_aresetn,
    xpu_ack_ctrl_if.slave s_axi,
    input  logic        pkt_header_valid_strobe,
    input  logic        byte_in_strobe,
    input  logic [7:0]  byte_in,
    input  logic [15:0] byte_count,
    input  logic        fcs_in_strobe,
    input  logic        fcs_ok,
    input  logic        phy_tx_done,
    output logic [47:0] mac_addr,
    output logic [47:0] addr1,
    output logic        addr1_valid,
    output logic        pkt_for_me,
    output logic        start_tx_ack,
    output logic        ack_tx_flag
);
    localparam int IDX_W = C_S00_AXI_ADDR_WIDTH - 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK_TX} state_t;

    logic [C_S00_AXI_DATA_WIDTH-1:0] reg16_reg, reg18_reg, reg20_reg, reg27_reg, reg30_reg, reg31_reg;
    logic [C_S00_AXI_DATA_WIDTH-1:0] rdata_reg, rd_mux, wmask;
    logic        awready_reg, bvalid_reg, arready_reg, rvalid_reg;
    logic [IDX_W-1:0] wr_idx, rd_idx;

    state_t      state_reg, state_next;
    logic [16:0] cnt_reg, cnt_next;
    logic        start_reg, start_next;
    logic [16:0] delay_sum, timeout_load;

    logic [1:0]  frame_type_reg;
    logic [47:0] addr1_reg, addr1_next;
    logic        addr1_done_reg, addr1_valid_reg, pkt_for_me_reg;
    logic [5:0]  a1_hit;
    logic        last_byte, type_ok, ack_qualified;

    logic unused_ok;
    assign unused_ok = &{1'b0, s_axi.s00_axi_awaddr[1:0], s_axi.s00_axi_araddr[1:0]};

    // ---------------- AXI4-Lite register slave ----------------
    assign wr_idx = s_axi.s00_axi_awaddr[C_S00_AXI_ADDR_WIDTH-1:2];
    assign rd_idx = s_axi.s00_axi_araddr[C_S00_AXI_ADDR_WIDTH-1:2];

    genvar gi;
    generate
        for (gi = 0; gi < C_S00_AXI_DATA_WIDTH/8; gi++) begin : g_wmask
            assign wmask[gi*8 +: 8] = {8{s_axi.s00_axi_wstrb[gi]}};
        end
    endgenerate

    function automatic logic [C_S00_AXI_DATA_WIDTH-1:0] merge_w(input logic [C_S00_AXI_DATA_WIDTH-1:0] old);
        return (old & ~wmask) | (s_axi.s00_axi_wdata & wmask);
    endfunction

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            awready_reg <= 1'b0;
            bvalid_reg  <= 1'b0;
            reg16_reg   <= '0;
            reg18_reg   <= '0;
            reg20_reg   <= '0;
            reg27_reg   <= '0;
            reg30_reg   <= '0;
            reg31_reg   <= '0;
        end else begin
            awready_reg <= s_axi.s00_axi_awvalid && s_axi.s00_axi_wvalid && !bvalid_reg && !awready_reg;
            if (awready_reg) begin
                bvalid_reg <= 1'b1;
                case (wr_idx)
                    IDX_W'(16): reg16_reg <= merge_w(reg16_reg);
                    IDX_W'(18): reg18_reg <= merge_w(reg18_reg);
                    IDX_W'(27): reg27_reg <= merge_w(reg27_reg);
                    IDX_W'(30): reg30_reg <= merge_w(reg30_reg);
                    IDX_W'(31): reg31_reg <= merge_w(reg31_reg);
                    default: ;
                endcase
            end else if (bvalid_reg && s_axi.s00_axi_bready) begin
                bvalid_reg <= 1'b0;
            end
            if (start_next) reg20_reg <= reg20_reg + 1'b1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            IDX_W'(16): rd_mux = reg16_reg;
            IDX_W'(18): rd_mux = reg18_reg;
            IDX_W'(20): rd_mux = reg20_reg;
            IDX_W'(27): rd_mux = reg27_reg;
            IDX_W'(30): rd_mux = reg30_reg;
            IDX_W'(31): rd_mux = reg31_reg;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            arready_reg <= s_axi.s00_axi_arvalid && !rvalid_reg && !arready_reg;
            if (arready_reg) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rd_mux;
            end else if (rvalid_reg && s_axi.s00_axi_rready) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    assign s_axi.s00_axi_awready = awready_reg;
    assign s_axi.s00_axi_wready  = awready_reg;
    assign s_axi.s00_axi_bresp   = 2'b00;
    assign s_axi.s00_axi_bvalid  = bvalid_reg;
    assign s_axi.s00_axi_arready = arready_reg;
    assign s_axi.s00_axi_rdata   = rdata_reg;
    assign s_axi.s00_axi_rresp   = 2'b00;
    assign s_axi.s00_axi_rvalid  = rvalid_reg;

    assign mac_addr = {reg31_reg[15:0], reg30_reg};

    // ---------------- MAC header parse (Addr1 is little-endian, bytes 4..9) ----------------
    generate
        for (gi = 0; gi < 6; gi++) begin : g_addr1
            assign a1_hit[gi] = byte_in_strobe && (byte_count == 16'(gi + 4));
            assign addr1_next[gi*8 +: 8] = a1_hit[gi] ? byte_in : addr1_reg[gi*8 +: 8];
        end
    endgenerate

    assign last_byte = byte_in_strobe && (byte_count == 16'd9);

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            frame_type_reg  <= '0;
            addr1_reg       <= '0;
            addr1_done_reg  <= 1'b0;
            addr1_valid_reg <= 1'b0;
            pkt_for_me_reg  <= 1'b0;
        end else if (pkt_header_valid_strobe) begin
            frame_type_reg  <= '0;
            addr1_reg       <= '0;
            addr1_done_reg  <= 1'b0;
            addr1_valid_reg <= 1'b0;
            pkt_for_me_reg  <= 1'b0;
        end else begin
            addr1_reg       <= addr1_next;
            addr1_valid_reg <= last_byte;
            if (byte_in_strobe && byte_count == 16'd0) frame_type_reg <= byte_in[3:2];
            if (last_byte) begin
                addr1_done_reg <= 1'b1;
                pkt_for_me_reg <= (addr1_next == mac_addr);
            end
        end
    end

    assign addr1       = addr1_reg;
    assign addr1_valid = addr1_valid_reg;
    assign pkt_for_me  = pkt_for_me_reg;

    // ---------------- ACK sequencing ----------------
    // Control frames (type 1) are excluded simply by having no enable path here.
    assign type_ok = ((frame_type_reg == 2'd0) && reg27_reg[0]) ||
                     ((frame_type_reg == 2'd2) && reg27_reg[2]);
    assign ack_qualified = fcs_in_strobe && fcs_ok && addr1_done_reg &&
                           (addr1_reg == mac_addr) && !addr1_reg[0] && type_ok;
    assign delay_sum    = {1'b0, reg16_reg[15:0]} + {1'b0, reg18_reg[15:0]};
    assign timeout_load = {1'b0, reg16_reg[31:16]} - 17'd1;

    // The counter is loaded one short so start_tx_ack lands D+1 cycles after the FCS strobe.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        start_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (ack_qualified) begin
                    if (delay_sum == 17'd0) begin
                        start_next = 1'b1;
                        state_next = S_ACK_TX;
                        cnt_next   = timeout_load;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = delay_sum - 17'd1;
                    end
                end
            end
            S_WAIT: begin
                if (pkt_header_valid_strobe) begin
                    state_next = S_IDLE;
                end else if (cnt_reg == 17'd0) begin
                    start_next = 1'b1;
                    state_next = S_ACK_TX;
                    cnt_next   = timeout_load;
                end else begin
                    cnt_next = cnt_reg - 17'd1;
                end
            end
            S_ACK_TX: begin
                if (phy_tx_done) begin
                    state_next = S_IDLE;
                end else if (reg16_reg[31:16] != 16'd0 && cnt_reg == 17'd0) begin
                    state_next = S_IDLE;
                end else if (cnt_reg != 17'd0) begin
                    cnt_next = cnt_reg - 17'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            start_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            start_reg <= start_next;
        end
    end

    assign start_tx_ack = start_reg;
    assign ack_tx_flag  = (state_reg == S_ACK_TX);
endmodule

// File: tb/tb_xpu_ack_ctrl.sv
// Scoreboard bench for xpu_ack_ctrl: stimulus queues expected AXI responses, Addr1
// values and ACK cycles; a negedge monitor pops and compares as the DUT presents them.
module tb_xpu_ack_ctrl;
    logic        s00_axi_aclk;
    logic        s00_axi_aresetn;
    logic        pkt_header_valid_strobe, byte_in_strobe, fcs_in_strobe, fcs_ok, phy_tx_done;
    logic [7:0]  byte_in;
    logic [15:0] byte_count;
    logic [47:0] mac_addr, addr1;
    logic        addr1_valid, pkt_for_me, start_tx_ack, ack_tx_flag;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [31:0] exp_rd[$];
    logic [1:0]  exp_b[$];
    logic [47:0] exp_a1[$];
    int          exp_ack[$];

    xpu_ack_ctrl_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    xpu_ack_ctrl #(.C_S00_AXI_DATA_WIDTH(32), .C_S00_AXI_ADDR_WIDTH(8)) dut (
        .s00_axi_aclk            (s00_axi_aclk),
        .s00_axi_aresetn         (s00_axi_aresetn),
        .s_axi                   (bus),
        .pkt_header_valid_strobe (pkt_header_valid_strobe),
        .byte_in_strobe          (byte_in_strobe),
        .byte_in                 (byte_in),
        .byte_count              (byte_count),
        .fcs_in_strobe           (fcs_in_strobe),
        .fcs_ok                  (fcs_ok),
        .phy_tx_done             (phy_tx_done),
        .mac_addr                (mac_addr),
        .addr1                   (addr1),
        .addr1_valid             (addr1_valid),
        .pkt_for_me              (pkt_for_me),
        .start_tx_ack            (start_tx_ack),
        .ack_tx_flag             (ack_tx_flag)
    );

    initial s00_axi_aclk = 1'b0;
    always #5 s00_axi_aclk = ~s00_axi_aclk;
    always @(posedge s00_axi_aclk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endfunction

    // Monitor: every DUT-presented response is compared against the head of its queue.
    always @(negedge s00_axi_aclk) begin
        if (bus.s00_axi_bvalid && bus.s00_axi_bready) begin
            if (exp_b.size() == 0) check("bresp_unexpected", 64'(bus.s00_axi_bresp), 64'hDEAD);
            else check("bresp", 64'(bus.s00_axi_bresp), 64'(exp_b.pop_front()));
            $display("[%0d] write response bresp=%0d", cyc, bus.s00_axi_bresp);
        end
        if (bus.s00_axi_rvalid && bus.s00_axi_rready) begin
            $display("[%0d] read data=%08h rresp=%0d", cyc, bus.s00_axi_rdata, bus.s00_axi_rresp);
            if (exp_rd.size() == 0) check("rdata_unexpected", 64'(bus.s00_axi_rdata), 64'hDEAD);
            else check("rdata", {30'd0, bus.s00_axi_rresp, bus.s00_axi_rdata}, 64'(exp_rd.pop_front()));
        end
        if (addr1_valid) begin
            $display("[%0d] addr1_valid addr1=%012h", cyc, addr1);
            if (exp_a1.size() == 0) check("addr1_unexpected", 64'(addr1), 64'hDEAD);
            else check("addr1", 64'(addr1), 64'(exp_a1.pop_front()));
        end
        if (start_tx_ack) begin
            $display("[%0d] start_tx_ack", cyc);
            if (exp_ack.size() == 0) check("ack_unexpected_cycle", 64'(cyc), 64'hFFFF_FFFF);
            else check("ack_cycle", 64'(cyc), 64'(exp_ack.pop_front()));
        end
    end

    task automatic tick();
        @(posedge s00_axi_aclk);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d);
        int n;
        exp_b.push_back(2'b00);
        bus.s00_axi_awaddr  = a;
        bus.s00_axi_wdata   = d;
        bus.s00_axi_wstrb   = 4'hF;
        bus.s00_axi_awvalid = 1'b1;
        bus.s00_axi_wvalid  = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!bus.s00_axi_awready && n < 20);
        if (!bus.s00_axi_awready) check("awready_timeout", 64'(0), 64'(1));
        tick();
        bus.s00_axi_awvalid = 1'b0;
        bus.s00_axi_wvalid  = 1'b0;
        n = 0;
        while (!bus.s00_axi_bvalid && n < 20) begin tick(); n++; end
        tick();
    endtask

    task automatic axi_read(input logic [7:0] a, input logic [31:0] e);
        int n;
        exp_rd.push_back(e);
        bus.s00_axi_araddr  = a;
        bus.s00_axi_arvalid = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!bus.s00_axi_arready && n < 20);
        if (!bus.s00_axi_arready) check("arready_timeout", 64'(0), 64'(1));
        tick();
        bus.s00_axi_arvalid = 1'b0;
        n = 0;
        while (!bus.s00_axi_rvalid && n < 20) begin tick(); n++; end
        tick();
    endtask

    // Header strobe, 128 MPDU bytes (FC 08 02, Addr1 at bytes 4..9), then FCS strobe.
    task automatic send_frame(input logic [47:0] a1, input logic ok, output int fcs_cyc);
        exp_a1.push_back(a1);
        tick();
        pkt_header_valid_strobe = 1'b1;
        tick();
        pkt_header_valid_strobe = 1'b0;
        for (int i = 0; i < 128; i++) begin
            byte_in_strobe = 1'b1;
            byte_count     = 16'(i);
            if (i == 0)                byte_in = 8'h08;
            else if (i == 1)           byte_in = 8'h02;
            else if (i >= 4 && i <= 9) byte_in = a1[8*(i-4) +: 8];
            else                       byte_in = 8'(i);
            tick();
        end
        byte_in_strobe = 1'b0;
        tick();
        fcs_in_strobe = 1'b1;
        fcs_ok        = ok;
        fcs_cyc       = cyc;
        tick();
        fcs_in_strobe = 1'b0;
        fcs_ok        = 1'b0;
    endtask

    task automatic wait_ack(output int s);
        int n;
        n = 0;
        while (!start_tx_ack && n < 200) begin tick(); n++; end
        if (!start_tx_ack) check("ack_wait_timeout", 64'(0), 64'(1));
        s = cyc;
    endtask

    localparam logic [47:0] MY_ADDR = 48'hFFEEDDCCBBAA;

    initial begin
        int fc, s;
        s00_axi_aresetn         = 1'b0;
        pkt_header_valid_strobe = 1'b0;
        byte_in_strobe          = 1'b0;
        byte_in                 = '0;
        byte_count              = '0;
        fcs_in_strobe           = 1'b0;
        fcs_ok                  = 1'b0;
        phy_tx_done             = 1'b0;
        bus.s00_axi_awaddr  = '0;
        bus.s00_axi_awvalid = 1'b0;
        bus.s00_axi_wdata   = '0;
        bus.s00_axi_wstrb   = '0;
        bus.s00_axi_wvalid  = 1'b0;
        bus.s00_axi_bready  = 1'b1;
        bus.s00_axi_araddr  = '0;
        bus.s00_axi_arvalid = 1'b0;
        bus.s00_axi_rready  = 1'b1;

        repeat (3) tick();
        check("rst_mac_addr", 64'(mac_addr), 64'(0));
        check("rst_outputs", {58'd0, start_tx_ack, ack_tx_flag, pkt_for_me, addr1_valid,
                              bus.s00_axi_bvalid, bus.s00_axi_rvalid}, 64'(0));
        check("rst_readies", {62'd0, bus.s00_axi_awready, bus.s00_axi_arready}, 64'(0));
        s00_axi_aresetn = 1'b1;
        tick();

        // MAC address programming and readback
        axi_write(8'h78, 32'hDDCCBBAA);
        axi_write(8'h7C, 32'h0000FFEE);
        check("mac_addr", 64'(mac_addr), 64'(MY_ADDR));
        axi_read(8'h78, 32'hDDCCBBAA);
        axi_read(8'h7C, 32'h0000FFEE);
        axi_write(8'h04, 32'h12345678);
        axi_read(8'h04, 32'h0);

        // Qualified frame with ACK timeout 20: ACK at +31, flag drops 20 cycles later
        axi_write(8'h40, 32'h00140014);
        axi_write(8'h48, 32'h0000000A);
        axi_write(8'h6C, 32'h00003FFF);
        send_frame(MY_ADDR, 1'b1, fc);
        exp_ack.push_back(fc + 31);
        check("pkt_for_me_match", 64'(pkt_for_me), 64'(1));
        wait_ack(s);
        check("flag_at_start", 64'(ack_tx_flag), 64'(1));
        while (cyc < s + 19) tick();
        check("flag_before_timeout", 64'(ack_tx_flag), 64'(1));
        tick();
        check("flag_after_timeout", 64'(ack_tx_flag), 64'(0));
        axi_read(8'h50, 32'd1);

        // No timeout; phy_tx_done 50 cycles after start ends the ACK
        axi_write(8'h40, 32'h00000014);
        send_frame(MY_ADDR, 1'b1, fc);
        exp_ack.push_back(fc + 31);
        wait_ack(s);
        while (cyc < s + 50) tick();
        check("flag_before_done", 64'(ack_tx_flag), 64'(1));
        phy_tx_done = 1'b1;
        tick();
        phy_tx_done = 1'b0;
        check("flag_after_done", 64'(ack_tx_flag), 64'(0));
        axi_read(8'h50, 32'd2);

        // Disqualified frames: bad FCS, foreign Addr1, data type disabled
        send_frame(MY_ADDR, 1'b0, fc);
        repeat (1000) tick();
        send_frame(48'h00EEDDCCBBAA, 1'b1, fc);
        check("pkt_for_me_foreign", 64'(pkt_for_me), 64'(0));
        repeat (1000) tick();
        axi_write(8'h6C, 32'h00003FFB);
        send_frame(MY_ADDR, 1'b1, fc);
        repeat (1000) tick();
        axi_read(8'h50, 32'd2);
        axi_write(8'h6C, 32'h00003FFF);

        // Medium busy: a new header 5 cycles after the qualified FCS cancels the ACK
        send_frame(MY_ADDR, 1'b1, fc);
        while (cyc < fc + 5) tick();
        pkt_header_valid_strobe = 1'b1;
        tick();
        pkt_header_valid_strobe = 1'b0;
        check("pkt_for_me_cleared", 64'(pkt_for_me), 64'(0));
        repeat (100) tick();
        axi_read(8'h50, 32'd2);

        // Reset during WAIT: no ACK, every register back to 0
        send_frame(MY_ADDR, 1'b1, fc);
        while (cyc < fc + 10) tick();
        s00_axi_aresetn = 1'b0;
        #1;
        check("async_rst_outputs", {61'd0, start_tx_ack, ack_tx_flag, pkt_for_me}, 64'(0));
        repeat (3) tick();
        s00_axi_aresetn = 1'b1;
        repeat (100) tick();
        check("post_rst_mac", 64'(mac_addr), 64'(0));
        axi_read(8'h40, 32'h0);
        axi_read(8'h48, 32'h0);
        axi_read(8'h50, 32'h0);
        axi_read(8'h6C, 32'h0);
        axi_read(8'h78, 32'h0);
        axi_read(8'h7C, 32'h0);

        tick();
        check("pending_acks", 64'(exp_ack.size()), 64'(0));
        check("pending_reads", 64'(exp_rd.size() + exp_b.size()), 64'(0));
        check("pending_addr1", 64'(exp_a1.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
